ram_load_arbiter: RTL and testbench

//  Shares the 16x8 program RAM between the CPU control path and a host program loader.

---
 rtl/ram_load_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_load_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_load_arbiter.sv
// Arbitrates the 16x8 program RAM between the CPU control path and a host byte loader.
// A load session waits for an instruction boundary, freezes the CPU, streams bytes in from address 0, then restarts the CPU.
`timescale 1ns/1ps
module ram_load_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic [CTRL_W-1:0] cpu_ctrl,
    input  logic [2:0]        cpu_step,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              loader_owns,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   load_count
);

    localparam int RI_BIT  = 13;
    localparam int HLT_BIT = 15;

    typedef enum logic [2:0] {
        IDLE, WAIT_BND, GRANT, WRITE, COMMIT, RESTART, RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic                armed_q, armed_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]     lcnt_q, lcnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                last_q;
    logic                capture;
    logic                passthru;
    logic                unused_ctrl;

    assign unused_ctrl = ^cpu_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Captured byte is only consumed in COMMIT, which always follows a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= cnt_q;
            data_q <= host_data;
            last_q <= host_last;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        lcnt_d  = lcnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!load_req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = WAIT_BND;
                end
            end
            WAIT_BND: begin
                if (cpu_step == 3'd0 || cpu_ctrl[HLT_BIT]) state_d = GRANT;
            end
            GRANT: begin
                cnt_d   = '0;
                lcnt_d  = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (host_valid) begin
                    capture = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                cnt_d  = cnt_q + ADDR_W'(1);
                lcnt_d = lcnt_q + (ADDR_W+1)'(1);
                // The top address ends the session even without host_last, so the counter never wraps.
                if (last_q || cnt_q == '1) state_d = RESTART;
                else                       state_d = WRITE;
            end
            RESTART: state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign passthru    = (state_q == IDLE) || (state_q == WAIT_BND);
    assign host_ready  = (state_q == WRITE);
    assign cpu_hold    = (state_q == GRANT) || (state_q == WRITE) ||
                         (state_q == COMMIT) || (state_q == RESTART);
    assign loader_owns = cpu_hold;
    assign cpu_restart = (state_q == RESTART);
    assign done        = (state_q == RELEASE);
    assign busy        = (state_q != IDLE);
    assign load_count  = lcnt_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (passthru) begin
            ram_we = cpu_ctrl[RI_BIT];
        end else if (state_q == COMMIT) begin
            ram_we    = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = data_q;
        end else if (loader_owns) begin
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Directed bench for ram_load_arbiter: per-cycle vector table plus hand sequences for long loads, backpressure and reset.
`timescale 1ns/1ps
module tb_ram_load_arbiter;

    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] AO  = 16'h0800;
    localparam logic [15:0] HLT = 16'h8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req, host_valid, host_last;
    logic [7:0]  host_data;
    logic        host_ready;
    logic [15:0] cpu_ctrl;
    logic [2:0]  cpu_step;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_hold, cpu_restart, ram_we, loader_owns, busy, done;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [4:0]  load_count;

    always #5 clk = ~clk;

    ram_load_arbiter dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .cpu_ctrl(cpu_ctrl), .cpu_step(cpu_step),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_hold(cpu_hold),
        .cpu_restart(cpu_restart), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .loader_owns(loader_owns), .busy(busy),
        .done(done), .load_count(load_count)
    );

    // Model RAM and pulse counters, fed by what the arbiter drives at each edge.
    logic [7:0] tb_ram [16];
    int we_cnt = 0, restart_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        if (ram_we === 1'b1) begin
            tb_ram[ram_addr] = ram_wdata;
            we_cnt++;
        end
        if (cpu_restart === 1'b1) restart_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // hin = {load_req, host_valid, host_last}; fl = {busy, cpu_hold, loader_owns, host_ready, cpu_restart, done}
    typedef struct packed {
        logic [2:0]  hin;
        logic [7:0]  hd;
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic [3:0]  ca;
        logic [7:0]  cw;
        logic        we;
        logic [3:0]  ra;
        logic [7:0]  rd;
        logic [5:0]  fl;
        logic [4:0]  lc;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int acc, base, rbase, dbase;
        logic got_done, tog;

        vecs[0]  = '{3'b000, 8'h00, RI|AO,  3'd1, 4'h5, 8'h2A, 1'b1, 4'h5, 8'h2A, 6'b000000, 5'd0};
        vecs[1]  = '{3'b000, 8'h00, 16'h0,  3'd1, 4'h3, 8'h55, 1'b0, 4'h3, 8'h55, 6'b000000, 5'd0};
        vecs[2]  = '{3'b000, 8'h00, RI|HLT, 3'd1, 4'hF, 8'hFF, 1'b1, 4'hF, 8'hFF, 6'b000000, 5'd0};
        vecs[3]  = '{3'b100, 8'h00, RI,     3'd2, 4'h7, 8'h11, 1'b1, 4'h7, 8'h11, 6'b000000, 5'd0};
        vecs[4]  = '{3'b100, 8'h00, RI,     3'd2, 4'h8, 8'h22, 1'b1, 4'h8, 8'h22, 6'b100000, 5'd0};
        vecs[5]  = '{3'b000, 8'h00, 16'h0,  3'd3, 4'h9, 8'h33, 1'b0, 4'h9, 8'h33, 6'b100000, 5'd0};
        vecs[6]  = '{3'b000, 8'h00, RI,     3'd0, 4'hA, 8'h44, 1'b1, 4'hA, 8'h44, 6'b100000, 5'd0};
        vecs[7]  = '{3'b000, 8'h00, RI,     3'd2, 4'hB, 8'h66, 1'b0, 4'h0, 8'h00, 6'b111000, 5'd0};
        vecs[8]  = '{3'b010, 8'h1E, RI,     3'd0, 4'hB, 8'h66, 1'b0, 4'h0, 8'h00, 6'b111100, 5'd0};
        vecs[9]  = '{3'b000, 8'h00, RI,     3'd0, 4'hB, 8'h66, 1'b1, 4'h0, 8'h1E, 6'b111000, 5'd0};
        vecs[10] = '{3'b010, 8'h2F, RI,     3'd0, 4'hB, 8'h66, 1'b0, 4'h0, 8'h00, 6'b111100, 5'd1};
        vecs[11] = '{3'b000, 8'h00, RI,     3'd0, 4'hB, 8'h66, 1'b1, 4'h1, 8'h2F, 6'b111000, 5'd1};
        vecs[12] = '{3'b011, 8'hE0, RI,     3'd0, 4'hB, 8'h66, 1'b0, 4'h0, 8'h00, 6'b111100, 5'd2};
        vecs[13] = '{3'b000, 8'h00, RI,     3'd0, 4'hB, 8'h66, 1'b1, 4'h2, 8'hE0, 6'b111000, 5'd2};
        vecs[14] = '{3'b000, 8'h00, RI,     3'd0, 4'hB, 8'h66, 1'b0, 4'h0, 8'h00, 6'b111010, 5'd3};
        vecs[15] = '{3'b000, 8'h00, RI,     3'd0, 4'hC, 8'h77, 1'b0, 4'hC, 8'h77, 6'b100001, 5'd3};
        vecs[16] = '{3'b000, 8'h00, RI,     3'd0, 4'hD, 8'h88, 1'b1, 4'hD, 8'h88, 6'b000000, 5'd3};

        rst_n = 1'b0; load_req = 0; host_valid = 0; host_last = 0; host_data = 0;
        cpu_ctrl = 0; cpu_step = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs",
               {ram_we, busy, cpu_hold, loader_owns, host_ready, cpu_restart, done, load_count}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Idle passthrough, boundary wait and a three-byte load, cycle by cycle.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            {load_req, host_valid, host_last} = vecs[i].hin;
            host_data = vecs[i].hd; cpu_ctrl = vecs[i].ctrl; cpu_step = vecs[i].step;
            cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cw;
            #1 chk($sformatf("vec%0d", i),
                   {ram_we, ram_addr, ram_wdata, busy, cpu_hold, loader_owns, host_ready, cpu_restart, done, load_count},
                   {vecs[i].we, vecs[i].ra, vecs[i].rd, vecs[i].fl, vecs[i].lc});
        end
        chk("short_ram0", tb_ram[0], 8'h1E);
        chk("short_ram1", tb_ram[1], 8'h2F);
        chk("short_ram2", tb_ram[2], 8'hE0);
        chk("short_restart_pulses", restart_cnt, 1);
        chk("short_done_pulses", done_cnt, 1);

        // Full load: 17 bytes offered with host_last low; the 16th ends the session.
        @(negedge clk);
        load_req = 1; cpu_step = 0; cpu_ctrl = 0; host_last = 0;
        acc = 0; got_done = 0; base = we_cnt; rbase = restart_cnt;
        for (int c = 0; c < 80 && !got_done; c++) begin
            @(negedge clk);
            host_valid = 1; host_data = 8'hA0 + 8'(acc);
            #1;
            if (done) got_done = 1;
            else if (host_ready) acc++;
        end
        chk("full_done_seen", got_done, 1);
        chk("full_accepted", acc, 16);
        chk("full_load_count", load_count, 16);
        chk("full_writes", we_cnt - base, 16);
        chk("full_restart", restart_cnt - rbase, 1);
        for (int a = 0; a < 16; a++) chk($sformatf("full_ram%0d", a), tb_ram[a], 8'hA0 + a);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 chk("level_req_no_rearm", {busy, host_ready}, 0);
        end
        chk("count_holds", load_count, 16);

        // HLT boundary with step != 0, then backpressured five-byte load with CPU writes masked.
        @(negedge clk) load_req = 0; host_valid = 0;
        @(negedge clk) load_req = 1; cpu_ctrl = HLT; cpu_step = 3'd5;
        #1 chk("hlt_idle", busy, 0);
        @(negedge clk) #1 chk("hlt_wait", {busy, cpu_hold}, 2'b10);
        @(negedge clk) #1 chk("hlt_grant", {cpu_hold, loader_owns, host_ready, ram_we}, 4'b1100);
        cpu_ctrl = HLT | RI; cpu_addr = 4'hF; cpu_wdata = 8'hEE;
        acc = 0; got_done = 0; tog = 0; base = we_cnt; rbase = restart_cnt; dbase = done_cnt;
        for (int c = 0; c < 80 && !got_done; c++) begin
            @(negedge clk);
            host_valid = tog && (acc < 5); host_data = 8'hC0 + 8'(acc); host_last = (acc == 4);
            #1;
            if (done) begin
                got_done = 1; cpu_ctrl = 0;
            end else if (host_ready) begin
                if (host_valid) acc++;
                tog = ~tog;
            end
        end
        chk("bp_done_seen", got_done, 1);
        chk("bp_load_count", load_count, 5);
        chk("bp_writes", we_cnt - base, 5);
        chk("bp_restart", restart_cnt - rbase, 1);
        chk("bp_done", done_cnt - dbase + 1, 1 + 0);
        for (int a = 0; a < 5; a++) chk($sformatf("bp_ram%0d", a), tb_ram[a], 8'hC0 + a);
        chk("bp_ram5_untouched", tb_ram[5], 8'hA5);
        chk("bp_cpu_write_masked", tb_ram[15], 8'hAF);
        host_valid = 0; host_last = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 chk("bp_level_req_idle", busy, 0);
        end

        // Reset in the middle of a session, after four bytes.
        @(negedge clk) load_req = 0;
        @(negedge clk) load_req = 1; cpu_ctrl = 0; cpu_step = 0;
        acc = 0; rbase = restart_cnt; dbase = done_cnt;
        for (int c = 0; c < 40 && acc < 4; c++) begin
            @(negedge clk);
            host_valid = 1; host_data = 8'h50 + 8'(acc);
            #1 if (host_ready) acc++;
        end
        chk("rst_accepted", acc, 4);
        @(negedge clk) host_valid = 0;
        #1 chk("rst_fourth_commit", {ram_we, ram_addr, ram_wdata}, {1'b1, 4'h3, 8'h53});
        @(negedge clk) rst_n = 0;
        #1 chk("rst_outputs", {cpu_hold, loader_owns, busy, ram_we, host_ready, load_count}, 0);
        for (int a = 0; a < 4; a++) chk($sformatf("rst_ram%0d", a), tb_ram[a], 8'h50 + a);
        chk("rst_ram4_kept", tb_ram[4], 8'hC4);
        chk("rst_no_restart", {restart_cnt - rbase, done_cnt - dbase}, 0);
        @(negedge clk) rst_n = 1; load_req = 0; cpu_ctrl = RI; cpu_addr = 4'h6; cpu_wdata = 8'h99;
        #1 chk("post_rst_passthru", {ram_we, ram_addr, ram_wdata, busy}, {1'b1, 4'h6, 8'h99, 1'b0});
        @(negedge clk) cpu_ctrl = 0;
        #1 chk("post_rst_idle", {busy, ram_we}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
